bus_responder: RTL and testbench

Memory-side end of the CPU bus driven by the control unit's read_write and address outputs.
- Accepts one request at a time and inserts a configurable number of wait states.
- Decodes the address into internal RAM, a small I/O register window, or unmapped space.
- Returns read data and a one-cycle ready strobe to the CPU.

---
 rtl/cpu_bus_pkg.sv | 28 ++
 rtl/bus_ram.sv | 27 ++
 rtl/bus_responder.sv | 173 +++++++++++++++++
 tb/tb_bus_responder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared encodings for the CPU bus: transfer direction, responder FSM states,
// address regions and I/O register offsets.
package cpu_bus_pkg;

   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACCESS
   } state_t;

   typedef enum logic [2:0] {
      RGN_RAM,
      RGN_IO_OUT,
      RGN_IO_IN,
      RGN_STATUS,
      RGN_UNMAPPED
   } region_t;

   localparam int unsigned IO_OFS_OUT    = 0;
   localparam int unsigned IO_OFS_IN     = 1;
   localparam int unsigned IO_OFS_STATUS = 2;

   localparam logic [7:0] UNMAPPED_RDATA = 8'hFF;

endpackage

// File: rtl/bus_ram.sv
// Synchronous single-port RAM with write enable and a registered read port
// that holds its last value while re is low.
module bus_ram #(
   parameter int DEPTH = 4096,
   parameter int WIDTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic             re,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // NOTE: no reset on the array or its read register, so it maps onto a RAM macro instead of a flop bank.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      if (re) rdata_q <= mem[addr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/bus_responder.sv
// Memory-side CPU bus responder: one request at a time, WAIT_STATES wait cycles,
// decodes RAM / 3-register I/O window / unmapped space, one-cycle ready strobe.
module bus_responder
   import cpu_bus_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 16,
   parameter int                    DATA_WIDTH  = 8,
   parameter int                    RAM_DEPTH   = 4096,
   parameter logic [ADDR_WIDTH-1:0] IO_BASE     = 16'h4000,
   parameter int                    WAIT_STATES = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  bus_request,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic                  read_write,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  ready,
   output logic                  bus_error,
   output logic [DATA_WIDTH-1:0] io_out,
   input  logic [DATA_WIDTH-1:0] io_in
);

   localparam int RAM_AW = $clog2(RAM_DEPTH);

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  rw_q, rw_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  rd_ram_q, rd_ram_d;
   logic                  err_q, err_d;
   logic                  err_sticky_q, err_sticky_d;
   logic [DATA_WIDTH-1:0] io_out_q, io_out_d;

   logic [ADDR_WIDTH-1:0] acc_addr;
   logic                  acc_rw;
   logic [DATA_WIDTH-1:0] acc_wdata;
   logic                  do_access;
   region_t               acc_rgn;
   logic                  ram_we, ram_re;
   logic [DATA_WIDTH-1:0] ram_rdata;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      rw_d      = rw_q;
      wdata_d   = wdata_q;
      acc_addr  = addr_q;
      acc_rw    = rw_q;
      acc_wdata = wdata_q;
      do_access = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus_request) begin
               addr_d  = address;
               rw_d    = read_write;
               wdata_d = wdata;
               // Zero wait states: the accepting edge is also the access edge, so use the live bus.
               if (WAIT_STATES == 0) begin
                  state_d   = ST_ACCESS;
                  do_access = 1'b1;
                  acc_addr  = address;
                  acc_rw    = read_write;
                  acc_wdata = wdata;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = 4'(WAIT_STATES - 1);
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d   = ST_ACCESS;
               do_access = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_ACCESS: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      acc_rgn = RGN_UNMAPPED;
      if (32'(acc_addr) < 32'(RAM_DEPTH))                         acc_rgn = RGN_RAM;
      else if (acc_addr == IO_BASE + ADDR_WIDTH'(IO_OFS_OUT))     acc_rgn = RGN_IO_OUT;
      else if (acc_addr == IO_BASE + ADDR_WIDTH'(IO_OFS_IN))      acc_rgn = RGN_IO_IN;
      else if (acc_addr == IO_BASE + ADDR_WIDTH'(IO_OFS_STATUS))  acc_rgn = RGN_STATUS;
   end

   always_comb begin
      rdata_d      = rdata_q;
      rd_ram_d     = rd_ram_q;
      err_d        = err_q;
      err_sticky_d = err_sticky_q;
      io_out_d     = io_out_q;
      ram_we       = do_access && (acc_rw == RW_WRITE) && (acc_rgn == RGN_RAM);
      ram_re       = do_access && (acc_rw == RW_READ)  && (acc_rgn == RGN_RAM);
      if (do_access) begin
         err_d = (acc_rgn == RGN_UNMAPPED);
         if (acc_rgn == RGN_UNMAPPED) err_sticky_d = 1'b1;
         if (acc_rw == RW_READ) begin
            rd_ram_d = (acc_rgn == RGN_RAM);
            unique case (acc_rgn)
               RGN_RAM:    rdata_d = rdata_q;
               RGN_IO_OUT: rdata_d = io_out_q;
               RGN_IO_IN:  rdata_d = io_in;
               RGN_STATUS: begin
                  rdata_d    = '0;
                  rdata_d[0] = err_sticky_q;
               end
               default:    rdata_d = DATA_WIDTH'(UNMAPPED_RDATA);
            endcase
         end else begin
            if (acc_rgn == RGN_IO_OUT) io_out_d     = acc_wdata;
            if (acc_rgn == RGN_STATUS) err_sticky_d = 1'b0;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         addr_q       <= '0;
         rw_q         <= RW_READ;
         wdata_q      <= '0;
         rdata_q      <= '0;
         rd_ram_q     <= 1'b0;
         err_q        <= 1'b0;
         err_sticky_q <= 1'b0;
         io_out_q     <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         rw_q         <= rw_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         rd_ram_q     <= rd_ram_d;
         err_q        <= err_d;
         err_sticky_q <= err_sticky_d;
         io_out_q     <= io_out_d;
      end
   end

   bus_ram #(
      .DEPTH (RAM_DEPTH),
      .WIDTH (DATA_WIDTH),
      .AW    (RAM_AW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (acc_addr[RAM_AW-1:0]),
      .wdata (acc_wdata),
      .rdata (ram_rdata)
   );

   // Both rdata sources are registers; the select is registered too.
   assign rdata     = rd_ram_q ? ram_rdata : rdata_q;
   assign ready     = (state_q == ST_ACCESS);
   assign bus_error = ready & err_q;
   assign io_out    = io_out_q;

endmodule

// File: tb/tb_bus_responder.sv
// Scoreboard bench for bus_responder: instance 0 has no wait states, instance 1 has one.
module tb_bus_responder;
   import cpu_bus_pkg::*;

   typedef struct {
      logic [7:0] rd;
      logic       err;
      string      name;
   } exp_t;

   logic             clk;
   logic             reset;
   logic [1:0]       req;
   logic [1:0][15:0] addr;
   logic [1:0]       rw;
   logic [1:0][7:0]  wd;
   logic [1:0][7:0]  rd;
   logic [1:0]       rdy;
   logic [1:0]       berr;
   logic [1:0][7:0]  io_o;
   logic [7:0]       io_in;

   exp_t             q0[$];
   exp_t             q1[$];
   logic [1:0][7:0]  model_rd;
   int               total = 0;
   int               bad   = 0;

   bus_responder #(.WAIT_STATES(0)) u_ws0 (
      .clk(clk), .reset(reset), .bus_request(req[0]), .address(addr[0]),
      .read_write(rw[0]), .wdata(wd[0]), .rdata(rd[0]), .ready(rdy[0]),
      .bus_error(berr[0]), .io_out(io_o[0]), .io_in(io_in)
   );

   bus_responder #(.WAIT_STATES(1)) u_ws1 (
      .clk(clk), .reset(reset), .bus_request(req[1]), .address(addr[1]),
      .read_write(rw[1]), .wdata(wd[1]), .rdata(rd[1]), .ready(rdy[1]),
      .bus_error(berr[1]), .io_out(io_o[1]), .io_in(io_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic push(input int d, input exp_t e);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic mon_check(input int d);
      exp_t e;
      int   sz;
      sz = (d == 0) ? q0.size() : q1.size();
      if (sz == 0) begin
         total++;
         bad++;
         $display("FAIL dut%0d spurious ready: got ready=1 expected no pending transaction", d);
      end else begin
         e = (d == 0) ? q0.pop_front() : q1.pop_front();
         check($sformatf("dut%0d %s rdata", d, e.name), 32'(rd[d]), 32'(e.rd));
         check($sformatf("dut%0d %s bus_error", d, e.name), 32'(berr[d]), 32'(e.err));
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         for (int d = 0; d < 2; d++) begin
            if (rdy[d]) mon_check(d);
            else if (berr[d]) check($sformatf("dut%0d bus_error without ready", d), 32'(berr[d]), 32'd0);
         end
      end
   end

   // One transaction; the bus is scrambled right after acceptance to prove it was latched.
   task automatic txn(input int d, input logic rwv, input logic [15:0] a, input logic [7:0] wv,
                      input logic [7:0] exp_rd, input logic exp_err, input string name);
      exp_t e;
      int   edges;
      @(negedge clk);
      if (rwv == RW_READ) model_rd[d] = exp_rd;
      e.rd   = model_rd[d];
      e.err  = exp_err;
      e.name = name;
      push(d, e);
      req[d]  = 1'b1;
      addr[d] = a;
      rw[d]   = rwv;
      wd[d]   = wv;
      @(posedge clk);
      edges = 1;
      @(negedge clk);
      req[d]  = 1'b0;
      addr[d] = a ^ 16'h0030;
      rw[d]   = ~rwv;
      wd[d]   = ~wv;
      while (!rdy[d] && edges < 20) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      check($sformatf("dut%0d %s latency", d, name), 32'(edges), 32'(d + 1));
      @(posedge clk);
   endtask

   // Back-to-back reads with bus_request held high throughout.
   task automatic burst(input int d, input logic [15:0] a, input int n, input logic [7:0] exp_rd);
      exp_t e;
      @(negedge clk);
      model_rd[d] = exp_rd;
      for (int i = 0; i < n; i++) begin
         e.rd   = exp_rd;
         e.err  = 1'b0;
         e.name = $sformatf("burst%0d", i);
         push(d, e);
      end
      req[d]  = 1'b1;
      addr[d] = a;
      rw[d]   = RW_READ;
      for (int i = 0; i < 2 * n; i++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("dut%0d burst ready cycle %0d", d, i), 32'(rdy[d]), 32'((i % 2) == 0));
      end
      req[d] = 1'b0;
      @(posedge clk);
   endtask

   task automatic check_reset_state(input string tag);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("%s dut%0d rdata", tag, d), 32'(rd[d]), 32'd0);
         check($sformatf("%s dut%0d ready", tag, d), 32'(rdy[d]), 32'd0);
         check($sformatf("%s dut%0d bus_error", tag, d), 32'(berr[d]), 32'd0);
         check($sformatf("%s dut%0d io_out", tag, d), 32'(io_o[d]), 32'd0);
      end
   endtask

   initial begin
      reset    = 1'b1;
      req      = '0;
      addr     = '0;
      rw       = '0;
      wd       = '0;
      io_in    = 8'h81;
      model_rd = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_state("reset");
      reset = 1'b0;

      txn(1, RW_WRITE, 16'h0010, 8'hA5, 8'h00, 1'b0, "wr 0010");
      txn(1, RW_READ,  16'h0010, 8'h00, 8'hA5, 1'b0, "rd 0010");

      txn(0, RW_WRITE, 16'h0010, 8'hA5, 8'h00, 1'b0, "wr 0010");
      burst(0, 16'h0010, 3, 8'hA5);

      txn(1, RW_WRITE, 16'h0020, 8'h77, 8'h00, 1'b0, "wr 0020");
      txn(1, RW_READ,  16'h0010, 8'h00, 8'hA5, 1'b0, "rd 0010 addr moved");
      txn(0, RW_WRITE, 16'h0020, 8'h77, 8'h00, 1'b0, "wr 0020");
      txn(0, RW_READ,  16'h0020, 8'h00, 8'h77, 1'b0, "rd 0020");

      txn(1, RW_WRITE, 16'h4000, 8'h3C, 8'h00, 1'b0, "wr io_out");
      check("io_out after write", 32'(io_o[1]), 32'h3C);
      txn(1, RW_READ,  16'h4000, 8'h00, 8'h3C, 1'b0, "rd io_out");
      txn(1, RW_READ,  16'h4001, 8'h00, 8'h81, 1'b0, "rd io_in");
      txn(1, RW_WRITE, 16'h4001, 8'h12, 8'h00, 1'b0, "wr io_in");
      check("io_out after io_in write", 32'(io_o[1]), 32'h3C);
      txn(1, RW_READ,  16'h4002, 8'h00, 8'h00, 1'b0, "rd status clean");
      txn(1, RW_READ,  16'h8000, 8'h00, 8'hFF, 1'b1, "rd unmapped");
      txn(1, RW_READ,  16'h4002, 8'h00, 8'h01, 1'b0, "rd status sticky");
      txn(1, RW_WRITE, 16'h4002, 8'h00, 8'h00, 1'b0, "wr status");
      txn(1, RW_READ,  16'h4002, 8'h00, 8'h00, 1'b0, "rd status cleared");
      txn(0, RW_WRITE, 16'h9001, 8'h44, 8'h00, 1'b1, "wr unmapped");
      txn(0, RW_READ,  16'h4000, 8'h00, 8'h00, 1'b0, "rd io_out untouched");

      txn(1, RW_WRITE, 16'h0011, 8'h00, 8'h00, 1'b0, "wr 0011 zero");
      txn(1, RW_READ,  16'h8000, 8'h00, 8'hFF, 1'b1, "rd unmapped pre-reset");

      // Abort a write in WAIT with an asynchronous reset.
      @(negedge clk);
      req[1]  = 1'b1;
      addr[1] = 16'h0011;
      rw[1]   = RW_WRITE;
      wd[1]   = 8'h55;
      @(posedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      req[1] = 1'b0;
      check_reset_state("mid-wait reset");
      @(posedge clk);
      @(negedge clk);
      check("ready held off in reset", 32'(rdy[1]), 32'd0);
      reset    = 1'b0;
      model_rd = '0;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         check("no ready after reset", 32'(rdy[1]), 32'd0);
      end

      txn(1, RW_READ, 16'h4002, 8'h00, 8'h00, 1'b0, "rd status after reset");
      txn(1, RW_READ, 16'h0011, 8'h00, 8'h00, 1'b0, "rd 0011 after abort");

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("dut0 scoreboard drained", 32'(q0.size()), 32'd0);
      check("dut1 scoreboard drained", 32'(q1.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
